// File: rtl/word_unpacker.sv
// word_unpacker
// -------------
// Accepts one wide packed word plus a "last byte index" meta field and
// serialises it into a byte stream, one byte per output handshake. A single
// word is held at a time. On the output handshake of the final byte, the
// next word can be accepted in the same edge, so back-to-back words stream
// with no idle cycle.
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   in_valid/in_ready  - word handshake (in_ready depends combinationally
//                        on out_ready when the last byte is being taken)
//   data_in, meta_in   - packed word (byte 0 = data_in[0]) and the index of
//                        its last valid byte
//   out_valid/out_ready- byte handshake
//   out_byte, out_idx  - current byte and its index within the word
//   out_last           - current byte is the final byte of the word
//   busy               - a word is held
module word_unpacker #(
    parameter int NBYTES = 32,
    parameter int BYTE_W = 8,
    parameter int META_W = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NBYTES-1:0][BYTE_W-1:0]  data_in,
    input  logic [META_W-1:0]              meta_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BYTE_W-1:0]              out_byte,
    output logic [META_W-1:0]              out_idx,
    output logic                           out_last,
    output logic                           busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [NBYTES-1:0][BYTE_W-1:0]   word_q, word_d;
    logic [META_W-1:0]               last_q, last_d;
    logic [META_W-1:0]               idx_q, idx_d;

    logic draining;
    logic out_fire;
    logic in_fire;

    always_comb begin
        // Outputs are masked by rst so nothing from a discarded word is
        // visible while reset is asserted.
        draining  = (state_q == DRAIN) && !rst;
        out_valid = draining;
        busy      = draining;
        out_last  = draining && (idx_q == last_q);
        out_byte  = draining ? word_q[idx_q] : '0;
        out_idx   = draining ? idx_q : '0;

        out_fire  = out_valid && out_ready;
        // Combinational out_ready -> in_ready path lets the next word load
        // on the same edge that retires the current last byte.
        in_ready  = !rst && ((state_q == IDLE) || (out_fire && out_last));
        in_fire   = in_valid && in_ready;

        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        idx_d   = idx_q;

        if (in_fire) begin
            word_d  = data_in;
            last_d  = meta_in;
            idx_d   = '0;
            state_d = DRAIN;
        end else if (out_fire) begin
            if (out_last) begin
                state_d = IDLE;
            end else begin
                // idx_q < last_q here, so this never wraps.
                idx_d = idx_q + META_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
        // Payload registers carry no reset; they are only observed in DRAIN.
        word_q <= word_d;
        last_q <= last_d;
    end

endmodule

// File: tb/tb_word_unpacker.sv
module tb_word_unpacker;

    localparam int NBYTES = 32;
    localparam int BYTE_W = 8;
    localparam int META_W = 5;

    logic                          clk;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic [NBYTES-1:0][BYTE_W-1:0] data_in;
    logic [META_W-1:0]             meta_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [BYTE_W-1:0]             out_byte;
    logic [META_W-1:0]             out_idx;
    logic                          out_last;
    logic                          busy;

    int vectors     = 0;
    int miscompares = 0;

    word_unpacker #(.NBYTES(NBYTES), .BYTE_W(BYTE_W), .META_W(META_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .meta_in   (meta_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of every byte still owed to the sink.
    // Accepting a word appends its meta+1 bytes; each byte handshake
    // retires the head; reset discards everything.
    typedef struct {
        logic [BYTE_W-1:0] b;
        logic [META_W-1:0] idx;
        logic              last;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        logic exp_v;
        logic exp_rdy;
        exp_t e;
        exp_v   = !rst && (exp_q.size() > 0);
        exp_rdy = !rst && ((exp_q.size() == 0) || (out_ready && exp_q[0].last));
        chk("cmp_out_valid", 32'(out_valid), 32'(exp_v));
        chk("cmp_busy", 32'(busy), 32'(exp_v));
        chk("cmp_in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_v) begin
            chk("cmp_out_byte", 32'(out_byte), 32'(exp_q[0].b));
            chk("cmp_out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            chk("cmp_out_last", 32'(out_last), 32'(exp_q[0].last));
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_v && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) begin
                for (int i = 0; i <= int'(meta_in); i++) begin
                    e.b    = data_in[i];
                    e.idx  = META_W'(i);
                    e.last = (i == int'(meta_in));
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input bit down);
        for (int i = 0; i < NBYTES; i++)
            data_in[i] = down ? 8'(base - 8'(i)) : 8'(base + 8'(i));
    endtask

    initial begin
        logic [7:0] exp_b2b [5];
        logic [7:0] exp_bp  [5];
        logic       rdy_bp  [5];
        logic       take;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; meta_in = '0; data_in = '0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_byte", 32'(out_byte), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Single word, meta 3: bytes 10..13
        fill(8'h10, 0); meta_in = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_byte", 32'(out_byte), 32'(8'h10 + 8'(k)));
            chk("t1_idx", 32'(out_idx), 32'(k));
            chk("t1_last", 32'(out_last), 32'(k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_in_ready_after", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Full word, meta 31: bytes FF..E0
        fill(8'hFF, 1); meta_in = 5'd31; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("t2_byte", 32'(out_byte), 32'(8'hFF - 8'(k)));
            chk("t2_idx", 32'(out_idx), 32'(k));
            chk("t2_last", 32'(out_last), 32'(k == 31));
            if (k == 31) chk("t2_final_byte", 32'(out_byte), 32'h E0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t2_no_wrap", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Single byte, meta 0
        data_in = '0; data_in[0] = 8'hA5; meta_in = 5'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_byte", 32'(out_byte), 32'h A5);
        chk("t3_last", 32'(out_last), 1);
        chk("t3_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_done", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Back-to-back: meta 1 (20,21) then meta 2 (30,31,32)
        exp_b2b[0] = 8'h20; exp_b2b[1] = 8'h21; exp_b2b[2] = 8'h30;
        exp_b2b[3] = 8'h31; exp_b2b[4] = 8'h32;
        fill(8'h20, 0); meta_in = 5'd1; in_valid = 1'b1;
        step();
        fill(8'h30, 0); meta_in = 5'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_valid", 32'(out_valid), 1);
            chk("t4_byte", 32'(out_byte), 32'(exp_b2b[k]));
            take = in_valid && in_ready;
            if (k == 1) chk("t4_load_on_last", 32'(take), 1);
            @(posedge clk); #1;
            if (take) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t4_done", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Backpressure on meta 2 word (40,41,42)
        rdy_bp[0] = 1; rdy_bp[1] = 0; rdy_bp[2] = 0; rdy_bp[3] = 1; rdy_bp[4] = 1;
        exp_bp[0] = 8'h40; exp_bp[1] = 8'h41; exp_bp[2] = 8'h41;
        exp_bp[3] = 8'h41; exp_bp[4] = 8'h42;
        fill(8'h40, 0); meta_in = 5'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            out_ready = rdy_bp[k];
            @(negedge clk);
            chk("t5_byte", 32'(out_byte), 32'(exp_bp[k]));
            chk("t5_last", 32'(out_last), 32'(k == 4));
            if (k == 2) chk("t5_hold_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_done", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Reset after byte 1 of a meta 5 word
        fill(8'h50, 0); meta_in = 5'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_valid", 32'(out_valid), 0);
        chk("t6_after_busy", 32'(busy), 0);
        @(posedge clk); #1;
        fill(8'h60, 0); meta_in = 5'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_new_idx", 32'(out_idx), 0);
        chk("t6_new_byte", 32'(out_byte), 32'h 60);
        @(posedge clk); #1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_unpacker.md
# word_unpacker

Converts one wide packed word (32 bytes, `[31:0][7:0]`) plus its 5-bit metadata field into a serial byte stream, one byte per accepted handshake. It is the consumer end of the wide-word/meta interface driven by the packing stage: it takes `data` and `meta` as produced there and presents bytes to a narrow byte-wide sink. It holds one word, applies valid/ready backpressure on both sides, and supports back-to-back words with no idle cycle.

## Interface

Parameters:
- `NBYTES`, 32: number of bytes per packed word.
- `BYTE_W`, 8: byte width.
- `META_W`, 5: width of the meta field; equals $clog2(NBYTES).

Ports:
- `clk`  in  1  the only clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a word is offered on `data_in`/`meta_in`.
- `in_ready`  out  1  unpacker can accept a word this cycle.
- `data_in`  in  [NBYTES-1:0][BYTE_W-1:0]  packed word; byte 0 is `data_in[0]`.
- `meta_in`  in  META_W  index of the last valid byte (0 means 1 byte; 31 means 32 bytes).
- `out_valid`  out  1  `out_byte` holds a valid byte.
- `out_ready`  in  1  sink accepts the byte this cycle.
- `out_byte`  out  BYTE_W  current byte.
- `out_idx`  out  META_W  index of the current byte within its word.
- `out_last`  out  1  current byte is the final byte of the word (`out_idx == meta`).
- `busy`  out  1  a word is held, meaning at least one byte is still pending.

## Operation

- The state machine has two states:
  - IDLE: no word is held.
  - DRAIN: a word is held, and its byte `idx` is presented.
- Registers:
  - `word_q`, a copy of `data_in`.
  - `last_q`, a copy of `meta_in`.
  - `idx_q`, a META_W counter.
- In IDLE:
  - `in_ready = 1`.
  - `in_valid & in_ready` captures `word_q` and `last_q`, clears `idx_q` to 0, and moves to DRAIN.
- In DRAIN:
  - `out_valid = 1`.
  - `out_byte = word_q[idx_q]`.
  - `out_idx = idx_q`.
  - `out_last = (idx_q == last_q)`.
- Output handshake `out_valid & out_ready`:
  - If not `out_last`, `idx_q` increments by 1.
  - If `out_last` and `in_valid`, the next word loads into `word_q`/`last_q`, `idx_q` is set to 0, and the state stays DRAIN. There is no bubble.
  - If `out_last` and not `in_valid`, the state moves to IDLE.
- `in_ready = (state==IDLE) | (out_valid & out_ready & out_last)`, forced to 0 while `rst` is high.
  - This is a combinational path from `out_ready` to `in_ready`, and it is intended.
- `idx_q` never exceeds `last_q`, so there is no wrap.
  - With `meta_in = 31`, `idx_q` reaches 31 and the word then terminates.
  - The counter is never incremented past 31.
- While `out_valid & ~out_ready`, `out_byte`, `out_idx` and `out_last` hold stable.
- `data_in` and `meta_in` are sampled only on an input handshake. At all other times they are don't-care.
- `busy = (state==DRAIN)`.

## Timing

- Reset, while `rst` is high and in the first cycle after it:
  - State is IDLE.
  - `out_valid = 0`, `out_last = 0`, `busy = 0`.
  - `out_byte = 0`, `out_idx = 0`.
  - `in_ready = 0` during reset and 1 in the first cycle after it.
- Latency: an input handshake in cycle N gives `out_valid = 1` with byte 0 in cycle N+1.
- Throughput: a word with meta M takes M+1 output handshakes. With `out_ready` held at 1, consecutive words give one byte per cycle continuously.
- Reset mid-word: the held word is discarded and the next cycle is IDLE with all outputs at their reset values. No partial byte is emitted after reset.
- Simultaneous last-byte output handshake and input handshake: both take effect in the same edge. The new word's byte 0 appears the next cycle.
- `out_ready` low on the last byte: `in_ready` stays 0, and the word is held indefinitely.

## Test plan

- Reset then single word:
  - Stimulus: `data_in[i]=i+8'h10`, `meta_in=3`, `out_ready=1`.
  - Required response: bytes 10,11,12,13 in cycles N+1..N+4, with `out_idx` 0..3 and `out_last` only on 13. After that, `busy=0` and `in_ready=1`.
- Full word:
  - Stimulus: `meta_in=31`, `data_in[i]=8'hFF-i`.
  - Required response: 32 bytes FF..E0, `out_idx` reaching 31, `out_last` on E0, no wrap to idx 0.
- Single byte:
  - Stimulus: `meta_in=0`.
  - Required response: exactly one byte with `out_last=1` in cycle N+1. `in_ready=1` in that same cycle when `out_ready=1`.
- Back-to-back:
  - Stimulus: `in_valid` held 1, two words with meta 1 and 2, `out_ready=1`.
  - Required response: 5 consecutive valid bytes with no gap cycle. The second word loads on the edge where the first word's last byte is accepted.
- Backpressure:
  - Stimulus: toggle `out_ready` 1,0,0,1 on a meta=2 word.
  - Required response: `out_byte`/`out_idx` stable while stalled, all 3 bytes delivered in order, no duplicates.
- Reset mid-word:
  - Stimulus: assert `rst` for 1 cycle after byte 1 of a meta=5 word.
  - Required response: next cycle `out_valid=0`, `busy=0`. The following word starts at `out_idx=0`.
